// File: rtl/seq_divider.sv
// Iterative restoring divider: one trial subtraction per cycle, start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_divider #(
  parameter int BITS = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [BITS-1:0] dividend_i,
  input  logic [BITS-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [BITS-1:0] quotient_o,
  output logic [BITS-1:0] remainder_o,
  output logic            flag_dz_o,
  output logic            flag_v_o
);

  // state  | meaning
  // IDLE   | waiting for start_i; results held
  // RUN    | one restoring step per edge, counter counts BITS down to 0
  // DONE   | results valid, done_o pulses for one cycle

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] rem_q, quo_sh_q, dvs_q;
  logic [BITS-1:0] quotient_q, remainder_q;
  logic [CW-1:0]   cnt_q;
  logic            flag_dz_q;

  logic            div_zero, last_iter, trial_ok;
  logic [BITS:0]   shifted;
  logic [BITS-1:0] rem_next, quo_next, quo_res, rem_res;
  logic [BITS-1:0] dvd_mag, dvs_mag;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q_q, neg_r_q, ovf_q, flag_v_q;

  always_comb begin
    dvd_mag = dividend_i[BITS-1] ? -dividend_i : dividend_i;
    dvs_mag = divisor_i[BITS-1]  ? -divisor_i  : divisor_i;
    quo_res = neg_q_q ? -quo_next : quo_next;
    rem_res = neg_r_q ? -rem_next : rem_next;
  end

  assign flag_v_o = flag_v_q;
`else
  always_comb begin
    dvd_mag = dividend_i;
    dvs_mag = divisor_i;
    quo_res = quo_next;
    rem_res = rem_next;
  end

  assign flag_v_o = 1'b0;
`endif

  assign div_zero  = (divisor_i == '0);
  assign last_iter = (cnt_q == CW'(1));

  // Only the compare needs the extra bit; the kept difference always fits BITS.
  always_comb begin
    shifted  = {rem_q, quo_sh_q[BITS-1]};
    trial_ok = (shifted >= {1'b0, dvs_q});
    rem_next = trial_ok ? (shifted[BITS-1:0] - dvs_q) : shifted[BITS-1:0];
    quo_next = {quo_sh_q[BITS-2:0], trial_ok};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = div_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy_o = 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rem_q       <= '0;
      quo_sh_q    <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      flag_dz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      ovf_q       <= 1'b0;
      flag_v_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
`ifdef DIVIDER_SIGNED_EN
            flag_v_q <= 1'b0;
`endif
            if (div_zero) begin
              quotient_q  <= '1;
              remainder_q <= dividend_i;
              flag_dz_q   <= 1'b1;
            end else begin
              flag_dz_q <= 1'b0;
              rem_q     <= '0;
              quo_sh_q  <= dvd_mag;
              dvs_q     <= dvs_mag;
              cnt_q     <= CW'(BITS);
`ifdef DIVIDER_SIGNED_EN
              neg_q_q   <= dividend_i[BITS-1] ^ divisor_i[BITS-1];
              neg_r_q   <= dividend_i[BITS-1];
              // MIN / -1: the magnitude core already yields MIN, only the flag differs
              ovf_q     <= (dividend_i == {1'b1, {(BITS-1){1'b0}}}) && (divisor_i == '1);
`endif
            end
          end
        end
        S_RUN: begin
          rem_q    <= rem_next;
          quo_sh_q <= quo_next;
          cnt_q    <= cnt_q - CW'(1);
          if (last_iter) begin
            quotient_q  <= quo_res;
            remainder_q <= rem_res;
`ifdef DIVIDER_SIGNED_EN
            flag_v_q    <= ovf_q;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign flag_dz_o   = flag_dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
// Honours DIVIDER_SIGNED_EN the same way the design does.
module tb_seq_divider;

  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] dividend = '0;
  logic [BITS-1:0] divisor = '0;
  logic            busy, done, flag_dz, flag_v;
  logic [BITS-1:0] quotient, remainder;

  int n_total = 0;
  int n_pass  = 0;
  logic [BITS-1:0] prev_q = '0;
  logic [BITS-1:0] prev_r = '0;

  seq_divider #(.BITS(BITS)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .busy_o      (busy),
    .done_o      (done),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .flag_dz_o   (flag_dz),
    .flag_v_o    (flag_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       output logic [BITS-1:0] q, output logic [BITS-1:0] r,
                       output logic dz, output logic v);
    int ia, ib, iq, ir;
    dz = 1'b0;
    v  = 1'b0;
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      ia = a[BITS-1] ? int'(a) - (1 << BITS) : int'(a);
      ib = b[BITS-1] ? int'(b) - (1 << BITS) : int'(b);
      if (ia == -(1 << (BITS-1)) && ib == -1) begin
        iq = ia;
        ir = 0;
        v  = 1'b1;
      end else begin
        iq = ia / ib;
        ir = ia % ib;
      end
`else
      ia = int'(a);
      ib = int'(b);
      iq = ia / ib;
      ir = ia % ib;
`endif
      q = iq[BITS-1:0];
      r = ir[BITS-1:0];
    end
  endtask

  // One full operation; poke >= 1 re-asserts start with junk operands on that cycle.
  task automatic run_div(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input int poke);
    logic [BITS-1:0] eq, er;
    logic edz, ev;
    int cyc, busy_cnt;
    bit got_done, overlap, held_ok;
    model(a, b, eq, er, edz, ev);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = BITS'($urandom);
    divisor = BITS'($urandom);
    cyc = 0;
    busy_cnt = 0;
    got_done = 0;
    overlap = 0;
    held_ok = 1;
    while (!got_done && cyc < 2 * BITS + 4) begin
      @(negedge clk);
      cyc++;
      if (busy && done) overlap = 1;
      if (busy) busy_cnt++;
      if (!done && (quotient !== prev_q || remainder !== prev_r)) held_ok = 0;
      if (done) got_done = 1;
      else if (cyc == poke) begin
        start = 1'b1;
        dividend = BITS'($urandom);
        divisor = BITS'($urandom);
      end else start = 1'b0;
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", cyc, (b == 0) ? 1 : BITS + 1);
    check("busy_cycles", busy_cnt, (b == 0) ? 0 : BITS);
    check("busy_done_overlap", 32'(overlap), 32'd0);
    check("held_until_done", 32'(held_ok), 32'd1);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("flag_dz", 32'(flag_dz), 32'(edz));
    check("flag_v", 32'(flag_v), 32'(ev));
    @(negedge clk);
    check("done_one_cycle", {30'd0, busy, done}, 32'd0);
    check("quotient_held", 32'(quotient), 32'(eq));
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    bit saw_done;
    logic [BITS-1:0] ra, rb;

    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, quotient, remainder, flag_dz, flag_v}, '0);
    rst_n = 1'b1;

    run_div(8'd100, 8'd7, -1);
    run_div(8'd5, 8'd0, -1);
    run_div(8'd255, 8'd1, -1);
    run_div(8'd3, 8'd200, -1);
    run_div(8'd200, 8'd200, -1);
    run_div(8'd100, 8'd7, 4);
    run_div(8'd9, 8'd3, BITS + 1);
    run_div(8'd128, 8'd255, -1);
    run_div(8'hF9, 8'd2, -1);
    run_div(8'd7, 8'hFE, -1);

    // Reset in the middle of RUN: abort with no done pulse.
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_reset", {busy, done, quotient, remainder, flag_dz, flag_v}, '0);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (BITS + 4) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    prev_q = '0;
    prev_r = '0;
    run_div(8'd9, 8'd3, -1);

    for (int i = 0; i < 40; i++) begin
      ra = BITS'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? BITS'($urandom_range(0, 3)) : BITS'($urandom);
      run_div(ra, rb, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, BITS)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
